bcd_share_sched: RTL and testbench

- Shared, iterative binary-to-BCD conversion engine for up to NREQ requesters, e.g. display/counter blocks that each need a 7-bit value shown as decimal digits.
- Round-robin arbitration picks one requester and latches its operand.
- Conversion is sequential double-dabble, one shift per clock; produces hundreds, tens and units digits.
- Result is returned with a done pulse tagged by requester ID.

---
 rtl/bcd_share_sched.sv | 216 +++++++++++++++++++++
 tb/tb_bcd_share_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_share_sched.sv
// -----------------------------------------------------------------------------
// bcd_share_sched
//
// Shared, iterative binary-to-BCD converter serving NREQ requesters.
// A round-robin arbiter picks one pending requester, latches its W-bit
// operand and runs a double-dabble conversion, one shift per clock. The
// three resulting BCD digits are returned with a one-cycle done pulse,
// tagged with the index of the requester that was served.
//
// Optional feature macro: BCD_LEADZERO_BLANK_EN
//   Defined   : leading-zero digits are replaced by 4'hF (blank code for a
//               7-segment decoder). tram blanks when 0; chuc blanks when
//               both tram and chuc are 0; donvi never blanks.
//   Undefined : plain BCD digits on all outputs.
//   Timing is identical either way.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   W     operand width in bits (4..9, result always fits in 3 digits)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   req      in   [NREQ]     request level per requester, held until granted
//   sohex    in   [NREQ*W]   operands, requester k at bits [k*W +: W]
//   gnt      out  [NREQ]     one-hot, one-cycle grant pulse
//   busy     out             high while a conversion is in progress
//   done     out             one-cycle pulse, result valid on the digits
//   done_id  out  [clog2]    requester index belonging to the result
//   tram     out  [4]        hundreds digit
//   chuc     out  [4]        tens digit
//   donvi    out  [4]        units digit
//
// Timing: grant is decided at edge E0 (gnt visible the following cycle),
// shifts happen on edges E1..EW, results load at E(W+1). The IDLE cycle
// carrying done may grant again, so peak throughput is one conversion per
// W+2 clocks.
// -----------------------------------------------------------------------------
module bcd_share_sched #(
    parameter int NREQ = 4,
    parameter int W    = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       sohex,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [3:0]              tram,
    output logic [3:0]              chuc,
    output logic [3:0]              donvi
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(W + 1);
    // Shift register: 12 BCD bits on top of the W binary bits.
    localparam int SRW = W + 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Digit helpers
    // -------------------------------------------------------------------------
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    // One double-dabble iteration: correct every BCD nibble, then shift.
    function automatic logic [SRW-1:0] dd_step(input logic [SRW-1:0] sr);
        logic [SRW-1:0] adj;
        adj            = sr;
        adj[W+3:W]     = add3(sr[W+3:W]);
        adj[W+7:W+4]   = add3(sr[W+7:W+4]);
        adj[W+11:W+8]  = add3(sr[W+11:W+8]);
        return {adj[SRW-2:0], 1'b0};
    endfunction

    // Maps the raw BCD field {hundreds, tens, units} to output digit codes.
    function automatic logic [11:0] fmt_digits(input logic [11:0] bcd);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        h = bcd[11:8];
        t = bcd[7:4];
        u = bcd[3:0];
`ifdef BCD_LEADZERO_BLANK_EN
        // Tens blanks only when the hundreds digit is also a leading zero.
        if (h == 4'd0 && t == 4'd0) begin
            t = 4'hF;
        end
        if (h == 4'd0) begin
            h = 4'hF;
        end
`endif
        return {h, t, u};
    endfunction

    // -------------------------------------------------------------------------
    // Operand unpacking
    // -------------------------------------------------------------------------
    logic [W-1:0] w_opnd [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_opnd
        assign w_opnd[g] = sohex[g*W +: W];
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t          r_state;
    logic [SRW-1:0]  r_sr;
    logic [CW-1:0]   r_cnt;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
    logic            r_done;
    logic [IDW-1:0]  r_done_id;
    logic [3:0]      r_tram;
    logic [3:0]      r_chuc;
    logic [3:0]      r_donvi;

    // -------------------------------------------------------------------------
    // Round-robin selection: first set req bit searching from r_ptr+1 upward,
    // wrapping modulo NREQ. r_ptr itself is examined last, so the requester
    // just served has the lowest priority next time.
    // -------------------------------------------------------------------------
    logic           w_any;
    logic [IDW-1:0] w_sel;
    logic [IDW-1:0] w_k;

    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_k   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_k = IDW'((int'(r_ptr) + i) % NREQ);
            if (!w_any && req[w_k]) begin
                w_any = 1'b1;
                w_sel = w_k;
            end
        end
    end

    logic [11:0] w_digits;
    assign w_digits = fmt_digits(r_sr[W+11:W]);

    // -------------------------------------------------------------------------
    // Controller and datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_id      <= '0;
            r_ptr     <= IDW'(NREQ - 1);
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_tram    <= 4'd0;
            r_chuc    <= 4'd0;
            r_donvi   <= 4'd0;
        end else begin
            // Pulses default low; set only on the edge that raises them.
            r_gnt  <= '0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sr    <= {12'd0, w_opnd[w_sel]};
                        r_cnt   <= '0;
                        r_id    <= w_sel;
                        r_ptr   <= w_sel;
                        r_gnt   <= NREQ'(1) << w_sel;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == CW'(W)) begin
                        // All W bits shifted in: publish the result.
                        r_tram    <= w_digits[11:8];
                        r_chuc    <= w_digits[7:4];
                        r_donvi   <= w_digits[3:0];
                        r_done_id <= r_id;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_sr  <= dd_step(r_sr);
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign tram    = r_tram;
    assign chuc    = r_chuc;
    assign donvi   = r_donvi;

endmodule

// File: tb/tb_bcd_share_sched.sv
// -----------------------------------------------------------------------------
// tb_bcd_share_sched
//
// Directed bench for bcd_share_sched (NREQ=4, W=7). Inputs are driven and
// outputs sampled on the falling edge. Expected digits come from a decimal
// model (v/100, (v/10)%10, v%10) with leading-zero blanking applied when
// BCD_LEADZERO_BLANK_EN is defined.
// -----------------------------------------------------------------------------
module tb_bcd_share_sched;

    localparam int NREQ = 4;
    localparam int W    = 7;
    localparam int IDW  = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] sohex;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic [IDW-1:0]    done_id;
    logic [3:0]        tram;
    logic [3:0]        chuc;
    logic [3:0]        donvi;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_share_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .sohex   (sohex),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .tram    (tram),
        .chuc    (chuc),
        .donvi   (donvi)
    );

    always #5 clk = ~clk;

    // Expected output digit codes {tram, chuc, donvi} for value v.
    function automatic logic [11:0] exp_dig(input int v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
`ifdef BCD_LEADZERO_BLANK_EN
        if (v < 10) t = 4'hF;
        if (v < 100) h = 4'hF;
`endif
        return {h, t, u};
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one request and observes it; performs no comparisons.
    // gcyc/dcyc are the cycle numbers (counted from the request) at which
    // gnt[id] and done were seen, or -1 if the bound expired.
    task automatic conv(input int id, input int v, output int gcyc,
                        output int dcyc, output logic [11:0] dig,
                        output int did);
        gcyc = -1;
        dcyc = -1;
        dig  = '0;
        did  = -1;
        @(negedge clk);
        sohex[id*W +: W] = W'(v);
        req[id] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (gnt[id] && gcyc < 0) begin
                gcyc = n;
                req[id] = 1'b0;
            end
            if (done) begin
                dcyc = n;
                dig  = {tram, chuc, donvi};
                did  = int'(done_id);
                break;
            end
        end
        req[id] = 1'b0;
    endtask

    task automatic test_reset();
        sohex = '0;
        do_reset();
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b want 0000", gnt);
        end
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_busy_done: got %b want 00", {busy, done});
        end
        n_checks++;
        if (done_id !== '0) begin
            n_fail++;
            $display("FAIL reset_done_id: got %0d want 0", done_id);
        end
        n_checks++;
        if ({tram, chuc, donvi} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_digits: got %h want 000", {tram, chuc, donvi});
        end
    endtask

    task automatic test_basic();
        int g, d, id;
        logic [11:0] dig;
        do_reset();
        conv(0, 127, g, d, dig, id);
        n_checks++;
        if (g !== 1) begin
            n_fail++;
            $display("FAIL basic_gnt_cycle: got %0d want 1", g);
        end
        n_checks++;
        if (d - g !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 8", d - g);
        end
        n_checks++;
        if (id !== 0) begin
            n_fail++;
            $display("FAIL basic_done_id: got %0d want 0", id);
        end
        n_checks++;
        if (dig !== exp_dig(127)) begin
            n_fail++;
            $display("FAIL basic_digits: got %h want %h", dig, exp_dig(127));
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_at_done: got %b want 0", busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got %b want 0", done);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tram, chuc, donvi} !== exp_dig(127)) begin
            n_fail++;
            $display("FAIL basic_hold: got %h want %h", {tram, chuc, donvi}, exp_dig(127));
        end
    endtask

    task automatic test_small_values();
        int g, d, id;
        logic [11:0] dig;
        int vals [3] = '{0, 5, 40};
        foreach (vals[k]) begin
            conv(1, vals[k], g, d, dig, id);
            n_checks++;
            if (dig !== exp_dig(vals[k]) || id !== 1) begin
                n_fail++;
                $display("FAIL small_value_%0d: got %h id %0d want %h id 1",
                         vals[k], dig, id, exp_dig(vals[k]));
            end
        end
    endtask

    task automatic test_two_req();
        int g0, g2, nd;
        int ids [2];
        logic [11:0] digs [2];
        do_reset();
        g0 = -1; g2 = -1; nd = 0;
        ids = '{-1, -1};
        digs = '{12'h0, 12'h0};
        @(negedge clk);
        sohex[0*W +: W] = W'(12);
        sohex[2*W +: W] = W'(34);
        req[0] = 1'b1;
        req[2] = 1'b1;
        for (int n = 1; n <= 30 && nd < 2; n++) begin
            @(negedge clk);
            if (gnt[0] && g0 < 0) begin g0 = n; req[0] = 1'b0; end
            if (gnt[2] && g2 < 0) begin g2 = n; req[2] = 1'b0; end
            if (done) begin
                ids[nd]  = int'(done_id);
                digs[nd] = {tram, chuc, donvi};
                nd++;
            end
        end
        req = '0;
        n_checks++;
        if (g0 !== 1 || g2 !== 10) begin
            n_fail++;
            $display("FAIL two_req_grant_cycles: got %0d,%0d want 1,10", g0, g2);
        end
        n_checks++;
        if (ids[0] !== 0 || ids[1] !== 2) begin
            n_fail++;
            $display("FAIL two_req_done_ids: got %0d,%0d want 0,2", ids[0], ids[1]);
        end
        n_checks++;
        if (digs[0] !== exp_dig(12) || digs[1] !== exp_dig(34)) begin
            n_fail++;
            $display("FAIL two_req_digits: got %h,%h want %h,%h",
                     digs[0], digs[1], exp_dig(12), exp_dig(34));
        end
    endtask

    task automatic test_all_held();
        int order [6];
        int ng;
        bit onehot_ok;
        do_reset();
        ng = 0;
        onehot_ok = 1'b1;
        order = '{-1, -1, -1, -1, -1, -1};
        for (int k = 0; k < NREQ; k++) sohex[k*W +: W] = W'(10 + k);
        req = '1;
        for (int n = 1; n <= 80 && ng < 6; n++) begin
            @(negedge clk);
            if (gnt !== '0) begin
                if (!$onehot(gnt)) onehot_ok = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (gnt[k]) order[ng] = k;
                end
                ng++;
            end
        end
        req = '0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (order[k] !== k % NREQ) begin
                n_fail++;
                $display("FAIL all_held_order_%0d: got %0d want %0d", k, order[k], k % NREQ);
            end
        end
        n_checks++;
        if (!onehot_ok) begin
            n_fail++;
            $display("FAIL all_held_onehot: got non-one-hot gnt want one-hot");
        end
    endtask

    task automatic test_abort();
        int g, d, id;
        logic [11:0] dig;
        bit saw_done;
        do_reset();
        @(negedge clk);
        sohex[0*W +: W] = W'(99);
        req[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_gnt: got %b want 0001", gnt);
        end
        req[0] = 1'b0;
        repeat (3) @(negedge clk);   // now in the 4th SHIFT cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({gnt, busy, done, done_id, tram, chuc, donvi} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got gnt=%b busy=%b done=%b id=%0d dig=%h want all 0",
                     gnt, busy, done, done_id, {tram, chuc, donvi});
        end
        saw_done = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL abort_no_done: got done/busy activity want none");
        end
        conv(3, 58, g, d, dig, id);
        n_checks++;
        if (dig !== exp_dig(58) || id !== 3) begin
            n_fail++;
            $display("FAIL abort_next_conv: got %h id %0d want %h id 3", dig, id, exp_dig(58));
        end
    endtask

    task automatic test_sweep();
        int g, d, id;
        logic [11:0] dig;
        do_reset();
        for (int v = 0; v < 128; v++) begin
            conv(1, v, g, d, dig, id);
            n_checks++;
            if (dig !== exp_dig(v) || id !== 1 || d - g !== 8) begin
                n_fail++;
                $display("FAIL sweep_%0d: got %h id %0d lat %0d want %h id 1 lat 8",
                         v, dig, id, d - g, exp_dig(v));
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        sohex = '0;
        test_reset();
        test_basic();
        test_small_values();
        test_two_req();
        test_all_held();
        test_abort();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
